// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Groups the fetch stage's control, instruction-memory and IF/ID
//            signals. The master side is the fetch stage itself.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    // Hazard / redirect control from downstream stages
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    // Instruction memory port
    logic [31:0] imem_data;
    logic [31:0] imem_address;

    // IF/ID register towards decode, plus status
    logic [31:0] instruction;
    logic [31:0] counter;
    logic        d_valid;
    logic [31:0] fetched_count;
    logic        misaligned;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  imem_data,
        output imem_address,
        output instruction,
        output counter,
        output d_valid,
        output fetched_count,
        output misaligned
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_target,
        output imem_data,
        input  imem_address,
        input  instruction,
        input  counter,
        input  d_valid,
        input  fetched_count,
        input  misaligned
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Single-cycle instruction fetch with stall, redirect/flush and an
//            IF/ID pipeline register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire logic      clock,
    input  wire logic      reset,
    fetch_stage_if.master  bus
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_counter;
    logic        r_d_valid;
    logic [31:0] r_fetched_count;
    logic        r_misaligned;

    logic        w_advance;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_bad_target;

    // Redirect outranks stall, so an advance needs both to be low.
    assign w_advance     = !bus.redirect_valid && !bus.stall;
    assign w_pc_plus4    = r_pc + c_pc_step;
    assign w_redirect_pc = {bus.redirect_target[31:2], 2'b00};
    assign w_bad_target  = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instruction <= NOP_WORD;
            r_counter     <= 32'd0;
            r_d_valid     <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc          <= w_redirect_pc;
            r_instruction <= NOP_WORD;
            r_counter     <= 32'd0;
            r_d_valid     <= 1'b0;
        end else if (w_advance) begin
            r_pc          <= w_pc_plus4;
            r_instruction <= bus.imem_data;
            r_counter     <= w_pc_plus4;
            r_d_valid     <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetched_count <= 32'd0;
        end else if (w_advance) begin
            r_fetched_count <= r_fetched_count + 32'd1;
        end
    end

    // Sticky until reset; only a fresh reset clears a misaligned redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (w_bad_target) begin
            r_misaligned <= 1'b1;
        end
    end

    assign bus.imem_address  = r_pc;
    assign bus.instruction   = r_instruction;
    assign bus.counter       = r_counter;
    assign bus.d_valid       = r_d_valid;
    assign bus.fetched_count = r_fetched_count;
    assign bus.misaligned    = r_misaligned;

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, address fetched first after reset.
REQ-002 Parameter NOP_WORD, default 32'h00000000, instruction word inserted on flush/reset (sll $0,$0,0).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit request to freeze PC and IF/ID register.
REQ-006 redirect_valid  input  1  taken branch/jump resolved downstream; flush and retarget.
REQ-007 redirect_target  input  32  new fetch address when redirect_valid=1.
REQ-008 imem_data  input  32  instruction memory read data, combinational from imem_address.
REQ-009 imem_address  output  32  current PC driven to instruction memory.
REQ-010 instruction  output  32  IF/ID register: instruction handed to decode.
REQ-011 counter  output  32  IF/ID register: PC+4 of the instruction in instruction.
REQ-012 d_valid  output  1  IF/ID register: 1 = instruction is a real fetched instruction, 0 = bubble.
REQ-013 fetched_count  output  32  number of instructions delivered to decode since reset.
REQ-014 misaligned  output  1  sticky flag: a redirect target with bits[1:0]!=0 was received.

Function
REQ-015 imem_address SHALL equal the internal PC register combinationally at all times.
REQ-016 Latency SHALL be one cycle: word at imem_address in cycle N appears on instruction in cycle N+1.
REQ-017 Priority each edge SHALL be: reset > redirect_valid > stall > normal advance.
REQ-018 Normal advance (no reset, redirect_valid=0, stall=0): PC <= PC+4; instruction <= imem_data; counter <= PC+4; d_valid <= 1.
REQ-019 Stall (redirect_valid=0, stall=1): PC, instruction, counter, d_valid SHALL hold their values; imem_address stays constant.
REQ-020 Redirect (redirect_valid=1, regardless of stall): PC <= {redirect_target[31:2],2'b00}; instruction <= NOP_WORD; counter <= 0; d_valid <= 0.
REQ-021 Redirect during stall SHALL flush and retarget in that same edge; the stall is not honoured for that cycle.
REQ-022 PC arithmetic SHALL be 32-bit modulo: PC=32'hFFFFFFFC advances to 32'h00000000 with no flag; counter likewise wraps to 0.
REQ-023 PC[1:0] SHALL always be 2'b00.
REQ-024 misaligned SHALL set on any edge with redirect_valid=1 and redirect_target[1:0]!=0, and stay set until reset.
REQ-025 fetched_count SHALL increment by 1 on exactly those edges where d_valid is loaded with 1 (REQ-018); it wraps modulo 2^32 and holds otherwise.
REQ-026 Back-to-back redirects SHALL each retarget; d_valid stays 0 until the first normal-advance edge after the last redirect.
REQ-027 imem_data SHALL be sampled only on normal-advance edges; its value during stall, redirect or reset is ignored.

Reset
REQ-028 On a rising edge with reset=1: PC <= RESET_PC; instruction <= NOP_WORD; counter <= 0; d_valid <= 0; fetched_count <= 0; misaligned <= 0.
REQ-029 Reset asserted mid-operation SHALL override concurrent stall and redirect_valid on that edge.
REQ-030 First edge after reset deasserts with stall=0 SHALL load the word at RESET_PC with d_valid=1.

Verification
REQ-031 Reset, then 4 free-running cycles, imem_data=PC-derived words -> instruction sequence words@0,4,8,12; counter 4,8,12,16; fetched_count 4.
REQ-032 Stall high 3 cycles while PC=8 -> imem_address stays 8, instruction/counter/d_valid unchanged, fetched_count unchanged; resumes loading word@8 on release.
REQ-033 redirect_valid=1, stall=1, target=32'h00000040 same cycle -> next cycle PC=0x40, instruction=NOP_WORD, d_valid=0; following cycle instruction=word@0x40, counter=0x44.
REQ-034 Redirect target 32'h00000023 -> PC=0x20, misaligned=1 and remains 1 through later cycles until reset.
REQ-035 Redirect to 32'hFFFFFFFC then advance -> counter=0 after first load, imem_address=0 next, no flag set.
REQ-036 Assert reset during active stall and redirect -> all outputs take REQ-028 values on that edge; imem_address=RESET_PC.
